// File: rtl/cacheline_adaptor_if.sv
// Arbiter-side line port and memory-side burst port of the cache-line adaptor.
// Latency: n/a (signal bundle only).
// Backpressure: none here; the slave stalls bursts on resp_i and completes the line with resp_o.
//   slave  : the adaptor (takes line requests and memory acks, drives bursts and the response)
//   master : the environment (arbiter plus burst memory)
interface cacheline_adaptor_if;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic         resp_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;

    modport slave (
        input  line_i, address_i, read_i, write_i, burst_i, resp_i,
        output line_o, resp_o, burst_o, address_o, read_o, write_o
    );

    modport master (
        output line_i, address_i, read_i, write_i, burst_i, resp_i,
        input  line_o, resp_o, burst_o, address_o, read_o, write_o
    );
endinterface

// File: rtl/cacheline_adaptor.sv
// Turns one 256-bit line read/write from the arbiter into a 4 x 64-bit memory burst.
// Latency: resp_o pulses 5 cycles after the request cycle with no wait states; each idle resp_i adds one.
// Backpressure: memory stalls beats by holding resp_i low; the arbiter holds its request until resp_o.
//   clk, rst          : clock and asynchronous active-high reset
//   bus.line_i/line_o : write line in, assembled read line out
//   bus.address_i     : line address; bits [4:0] are dropped
//   bus.read_i/write_i: line requests (read has priority), completed by the resp_o pulse
//   bus.burst_i/o, address_o, read_o, write_o, resp_i : memory burst port, one beat per resp_i
module cacheline_adaptor (
    input  logic                clk,
    input  logic                rst,
    cacheline_adaptor_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t        state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          resp_q, resp_d;
    logic          read_q, read_d;
    logic          write_q, write_d;
    logic [255:0]  line_q, line_d;
    logic [255:0]  wbuf_q, wbuf_d;
    logic [63:0]   burst_q, burst_d;
    logic [31:0]   addr_q, addr_d;
    logic [7:0]    beat_base;
    logic [7:0]    next_base;

    // Bit offset of the current beat and of the one after it within a line.
    assign beat_base = {cnt_q, 6'b0};
    assign next_base = {cnt_q + 2'd1, 6'b0};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        resp_d  = 1'b0;
        read_d  = read_q;
        write_d = write_q;
        line_d  = line_q;
        wbuf_d  = wbuf_q;
        burst_d = burst_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: begin
                if (bus.read_i) begin
                    state_d = READ;
                    addr_d  = {bus.address_i[31:5], 5'b0};
                    cnt_d   = 2'd0;
                    read_d  = 1'b1;
                end else if (bus.write_i) begin
                    state_d = WRITE;
                    addr_d  = {bus.address_i[31:5], 5'b0};
                    cnt_d   = 2'd0;
                    write_d = 1'b1;
                    wbuf_d  = bus.line_i;
                    // Present beat 0 from the first WRITE cycle on.
                    burst_d = bus.line_i[63:0];
                end
            end
            READ: begin
                if (bus.resp_i) begin
                    line_d[beat_base +: 64] = bus.burst_i;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = DONE;
                        read_d  = 1'b0;
                        resp_d  = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (bus.resp_i) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = DONE;
                        write_d = 1'b0;
                        resp_d  = 1'b1;
                    end else begin
                        // Advance to the next beat only after memory took this one.
                        burst_d = wbuf_q[next_base +: 64];
                    end
                end
            end
            DONE: begin
                // Request inputs are deliberately not looked at here.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            resp_q  <= 1'b0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            line_q  <= '0;
            wbuf_q  <= '0;
            burst_q <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
            read_q  <= read_d;
            write_q <= write_d;
            line_q  <= line_d;
            wbuf_q  <= wbuf_d;
            burst_q <= burst_d;
            addr_q  <= addr_d;
        end
    end

    assign bus.resp_o    = resp_q;
    assign bus.read_o    = read_q;
    assign bus.write_o   = write_q;
    assign bus.line_o    = line_q;
    assign bus.burst_o   = burst_q;
    assign bus.address_o = addr_q;
endmodule
